// File: rtl/alu_pkg.sv
// Shared opcode, select-width and FSM-state definitions for the one-hot ALU,
// its issue controller and the instruction decoder.
package alu_pkg;

  localparam int OPDEC_W = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOTA = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_LAST = OP_XNOR;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/alu_op_onehot.sv
// Binary opcode to one-hot ALU select; opcodes past OP_LAST yield an all-zero
// select and raise the illegal flag.
module alu_op_onehot #(
  parameter int OPDEC_W = 16
) (
  input  logic [3:0]         op,
  output logic [OPDEC_W-1:0] onehot,
  output logic               illegal
);
  import alu_pkg::*;

  always_comb begin
    illegal = (op > OP_LAST);
    onehot  = '0;
    if (!illegal) onehot = {{(OPDEC_W-1){1'b0}}, 1'b1} << op;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the one-hot ALU: accept, hold operands for a
// settle window, capture and present the result. ALU_ISSUE_ACC_EN adds req_acc
// to chain the last transferred result into operand A.
//
//   state  | meaning
//   IDLE   | ready for a request, ALU select cleared
//   SETTLE | operands/select held, settle counter running
//   RESP   | captured result presented until consumer takes it
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int OPDEC_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [7:0]         req_a,
  input  logic [7:0]         req_b,
`ifdef ALU_ISSUE_ACC_EN
  input  logic               req_acc,
`endif
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [OPDEC_W-1:0] alu_opdec,
  input  logic [3:0]         alu_rl,
  input  logic [3:0]         alu_rh,
  input  logic               alu_neg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_data,
  output logic               rsp_neg,
  output logic               rsp_err
);
  import alu_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               illegal_q;
  logic [OPDEC_W-1:0] dec_onehot;
  logic               dec_illegal;
  logic [7:0]         a_next;
  logic               accept;

  alu_op_onehot #(.OPDEC_W(OPDEC_W)) u_dec (
    .op      (req_op),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef ALU_ISSUE_ACC_EN
  logic [7:0] acc;

  // Errored results never become the chaining source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (rsp_valid && rsp_ready && !rsp_err) begin
      acc <= rsp_data;
    end
  end

  assign a_next = req_acc ? acc : req_a;
`else
  assign a_next = req_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      illegal_q <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_opdec <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_neg   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a     <= a_next;
            alu_b     <= req_b;
            alu_opdec <= dec_onehot;
            illegal_q <= dec_illegal;
            cnt       <= CNT_LOAD;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            rsp_data  <= {alu_rh, alu_rl};
            rsp_neg   <= alu_neg;
            rsp_err   <= illegal_q;
            rsp_valid <= 1'b1;
            alu_opdec <= '0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Front-end sequencer for the 8-bit one-hot ALU. It accepts an operation request on a valid/ready handshake, registers both operands and the binary opcode, and decodes the opcode to the ALU's 16-bit one-hot select. After a settle window it captures the ALU's nibble outputs and sign flag. It then presents a single registered 8-bit result on a second valid/ready handshake. It sits between the register file/control path and the ALU.

Parameters:
SETTLE_CYCLES, 1, cycles the ALU select and operands are held stable before capture (1..15)
OPDEC_W, 16, width of the one-hot ALU select

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  4  binary opcode: 0 ADD, 1 SUB, 2 NOT A, 3 NAND, 4 NOR, 5 AND, 6 OR, 7 XOR, 8 XNOR, 9-15 illegal
req_a  in  8  operand A
req_b  in  8  operand B
alu_a  out  8  registered operand A to ALU
alu_b  out  8  registered operand B to ALU
alu_opdec  out  16  one-hot select to ALU; bit n set for opcode n
alu_rl  in  4  ALU result low nibble
alu_rh  in  4  ALU result high nibble
alu_neg  in  1  ALU sign flag; SUB only
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_data  out  8  captured result {alu_rh, alu_rl}
rsp_neg  out  1  captured sign flag
rsp_err  out  1  request carried an illegal opcode

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE. Outputs: req_ready=1, alu_a=0, alu_b=0, alu_opdec=0, rsp_valid=0, rsp_data=0, rsp_neg=0, rsp_err=0, settle counter=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1; alu_opdec=0.
  - On req_valid&&req_ready: latch req_a→alu_a and req_b→alu_b.
  - Decode req_op→alu_opdec: 1<<req_op for 0-8; all zeros for 9-15.
  - Latch the illegal flag, load counter=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - req_ready=0; operands and alu_opdec held constant.
  - Counter decrements each cycle.
  - When counter==0, on that edge: rsp_data<={alu_rh,alu_rl}, rsp_neg<=alu_neg, rsp_err<=illegal flag, rsp_valid<=1, alu_opdec<=0. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_neg and rsp_err stable until transfer.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - req_ready stays 0 in RESP. No skid; one outstanding operation at a time.
- Latency: accept edge to rsp_valid high = SETTLE_CYCLES+1 edges (2 at default). Throughput: at most one op per SETTLE_CYCLES+2 cycles.
- Arithmetic: all width rules are inherited from the ALU. ADD wraps modulo 256 with no carry out. SUB returns |A-B| with rsp_neg=1 when A<B. The controller does no arithmetic.
- Illegal opcode: the op still runs the full sequence with alu_opdec=0. ALU outputs 0, so rsp_data=0x00, rsp_neg=0, rsp_err=1.
- alu_opdec is always one-hot or zero, never multi-hot.
- rsp_ready high while not in RESP is ignored.
- req_valid high outside IDLE is ignored; the requester must hold it until req_ready.
- rst_n low mid-operation: the in-flight op is discarded and no response is produced. All outputs take reset values immediately.

Optional Feature:
ALU_ISSUE_ACC_EN:
- Defined:
  - Adds input port req_acc (1 bit).
  - If req_acc=1 at accept, alu_a is loaded from the last transferred rsp_data instead of req_a. This enables chained ops.
  - The accumulator register is 0 after reset. It updates only on rsp_valid&&rsp_ready, and never when rsp_err=1.
- Undefined: no req_acc port and no accumulator register; alu_a always comes from req_a.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_XNOR (0-8) and OP_LAST=8
  - OPDEC_W=16
  - FSM state encodings
  - Shared by the ALU, this block, and the future instruction decoder.
- One sub-module: alu_op_onehot. Purely combinational 4→16 decoder with an illegal flag output, reused by the instruction decoder.

Test Plan:
- ADD, req_a=0x3C, req_b=0x05, op=0 -> alu_opdec=0x0001 during SETTLE; rsp_data=0x41, neg=0, err=0; rsp_valid 2 cycles after accept.
- SUB, a=0x03, b=0x05, op=1 -> rsp_data=0x02, rsp_neg=1. Then a=0x05, b=0x03 -> rsp_data=0x02, rsp_neg=0.
- ADD wrap, a=0xF0, b=0x20 -> rsp_data=0x10, neg=0. XNOR, a=0xAA, b=0x0F, op=8 -> alu_opdec=0x0100, rsp_data=0x5A.
- Illegal op=12, a=0xFF, b=0xFF -> alu_opdec=0x0000 throughout; rsp_data=0x00, rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 and a second request pending -> req_ready=0, rsp outputs stable. Second request accepted the cycle after rsp_ready=1.
- Reset mid-SETTLE: drop rst_n with SETTLE_CYCLES=4, counter=2 -> immediate reset values, no rsp_valid. After release, the next request completes normally.
